// File: rtl/diferential_rvb2_pkg.sv
// Shared types for the nibble-serial RV32I-style ALU slice: opcodes, FSM states, opcode width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package diferential_rvb2_pkg;

    localparam int OP_W = 4;

    // RV integer ALU operations; encodings 10-15 are reserved and yield 0.
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        EXEC      = 3'd3,
        SHIFT_OUT = 3'd4
    } state_e;

endpackage

// File: rtl/diferential_rvb2_alu_core.sv
// Combinational RV integer ALU: (op, a, b) -> (result, carry).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; evaluated whenever the parent samples it.
//
// Ports:
//   i_op     [OP_W-1:0]  opcode (op_e encoding; reserved codes give result 0)
//   i_a      [XLEN-1:0]  operand A
//   i_b      [XLEN-1:0]  operand B (only the low $clog2(XLEN) bits for shifts)
//   o_result [XLEN-1:0]  ALU result
//   o_carry              carry-out of ADD, NOT borrow of SUB, 0 otherwise
`timescale 1ns/1ps
module diferential_rvb2_alu_core
    import diferential_rvb2_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_carry
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_diff;
    logic [SHW-1:0]  w_shamt;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    // Subtract as A + ~B + 1 so the top bit is directly the NOT-borrow.
    assign w_diff  = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[XLEN-1:0];
                o_carry  = w_sum[XLEN];
            end
            OP_SUB: begin
                o_result = w_diff[XLEN-1:0];
                o_carry  = w_diff[XLEN];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = $signed(i_a) >>> w_shamt;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/diferential_rvb2_alu.sv
// Nibble-serial ALU slice: loads opcode, A and B beat-wise, executes one op, streams result out.
// Latency: 2 cycles from final B beat to first out_valid; NB result beats back to back.
// Backpressure: none on output; in_valid is dropped while busy (EXEC / SHIFT_OUT), never queued.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid, in_data     one input beat (opcode, then A, then B, LSB beat first)
//   busy                  high during EXEC and SHIFT_OUT
//   out_valid, out_data   result beats, LSB beat first
//   flags {carry, zero}   only when DIFERENTIAL_RVB2_FLAGS_EN is defined
`timescale 1ns/1ps
module diferential_rvb2_alu
    import diferential_rvb2_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] out_data
`ifdef DIFERENTIAL_RVB2_FLAGS_EN
    ,
    output logic [1:0]    flags
`endif
);

    localparam int            NB   = XLEN / DW;
    localparam int            CW   = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [OP_W-1:0] r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_r;
    logic            r_busy;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;

    logic [XLEN-1:0] w_result;
    logic            w_carry;
    logic            w_last;

    assign w_last = (r_cnt == LAST);

    diferential_rvb2_alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

`ifdef DIFERENTIAL_RVB2_FLAGS_EN
    logic [1:0] r_flags;
    assign flags = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 2'b00;
        end else if (r_state == EXEC) begin
            r_flags <= {w_carry, (w_result == '0)};
        end
    end
`else
    logic w_unused_carry;
    assign w_unused_carry = w_carry;
`endif

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // The EXEC cycle already presents result beat 0, so SHIFT_OUT only has to
    // supply beats 1..NB-1 and then drop out_valid on its last counter value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_r         <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_data[OP_W-1:0];
                        r_cnt   <= '0;
                        r_state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        r_a <= {in_data, r_a[XLEN-1:DW]};
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        r_b <= {in_data, r_b[XLEN-1:DW]};
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= EXEC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_r         <= w_result >> DW;
                    r_out_data  <= w_result[DW-1:0];
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    if (w_last) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_out_data <= r_r[DW-1:0];
                        r_r        <= r_r >> DW;
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diferential_rvb2_alu.sv
// Self-checking bench: directed and random ops against a behavioural RV ALU model.
// Latency: checks the 2-cycle final-B-to-first-beat latency on every op.
// Backpressure: drives in_valid noise while busy and expects it to be ignored.
`timescale 1ns/1ps
module tb_diferential_rvb2_alu;

    localparam int XLEN = 32;
    localparam int DW   = 4;
    localparam int NB   = XLEN / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out_data;

    logic          in_valid2;
    logic [7:0]    in_data2;
    logic          busy2;
    logic          out_valid2;
    logic [7:0]    out_data2;

`ifdef DIFERENTIAL_RVB2_FLAGS_EN
    logic [1:0]    flags;
    logic [1:0]    flags2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    diferential_rvb2_alu #(.XLEN(XLEN), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef DIFERENTIAL_RVB2_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    diferential_rvb2_alu #(.XLEN(16), .DW(8)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .busy      (busy2),
        .out_valid (out_valid2),
        .out_data  (out_data2)
`ifdef DIFERENTIAL_RVB2_FLAGS_EN
        ,
        .flags     (flags2)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model straight from the RV integer op definitions.
    function automatic void ref_alu(input int op, input bit [31:0] a, input bit [31:0] b,
                                    output bit [31:0] r, output bit c);
        longint unsigned s;
        int sh;
        sh = int'(b % 32);
        r  = 32'd0;
        c  = 1'b0;
        case (op)
            0: begin
                s = a;
                s = s + b;
                r = s[31:0];
                c = (s >= 64'h1_0000_0000);
            end
            1: begin
                r = a - b;
                c = (a >= b);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << sh;
            6: r = a >> sh;
            7: r = $signed(a) >>> sh;
            8: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_op(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                           input bit gaps, input int n_send);
        bit [3:0] beats[$];
        beats.push_back(op);
        for (int i = 0; i < NB; i++) beats.push_back(a[4*i +: 4]);
        for (int i = 0; i < NB; i++) beats.push_back(b[4*i +: 4]);
        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 4'($urandom);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beats[i];
        end
    endtask

    task automatic run_op(input string tag, input bit [3:0] op, input bit [31:0] a,
                          input bit [31:0] b, input bit gaps, input bit noise);
        bit [31:0] er;
        bit [31:0] got;
        bit        ec;
        int        k;
        int        nb;
        ref_alu(int'(op), a, b, er, ec);
        send_op(op, a, b, gaps, 1 + 2*NB);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            in_valid = noise ? 1'($urandom) : 1'b0;
            in_data  = 4'($urandom);
        end while (!out_valid && k < 12);
        check_eq({tag, " latency"}, 64'(k), 64'd2);
        check_eq({tag, " busy"}, 64'(busy), 64'd1);
`ifdef DIFERENTIAL_RVB2_FLAGS_EN
        check_eq({tag, " flags"}, 64'(flags), 64'({ec, (er == 32'd0)}));
`endif
        got = 32'd0;
        nb  = 0;
        while (out_valid && nb < 2*NB) begin
            if (nb < NB) got[4*nb +: 4] = out_data;
            nb++;
            @(negedge clk);
            // Only poke in_valid while the DUT still streams, so nothing starts in IDLE.
            in_valid = (noise && out_valid) ? 1'($urandom) : 1'b0;
            in_data  = 4'($urandom);
        end
        in_valid = 1'b0;
        check_eq({tag, " result"}, 64'(got), 64'(er));
        check_eq({tag, " beats"}, 64'(nb), 64'(NB));
        check_eq({tag, " busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int        cnt;
        int        k;
        bit [15:0] got16;
        bit [7:0]  beats16[5];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid2 = 1'b0;
        in_data2  = '0;
        do_reset();

        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst out_valid", 64'(out_valid), 64'd0);
        check_eq("rst out_data", 64'(out_data), 64'd0);
        check_eq("rst out_valid16", 64'(out_valid2), 64'd0);
`ifdef DIFERENTIAL_RVB2_FLAGS_EN
        check_eq("rst flags", 64'(flags), 64'd0);
`endif

        run_op("add",      4'd0,  32'd5,          32'd3,          1'b0, 1'b0);
        run_op("sub_neg",  4'd1,  32'd0,          32'd1,          1'b0, 1'b0);
        run_op("sub_zero", 4'd1,  32'd7,          32'd7,          1'b0, 1'b0);
        run_op("and",      4'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  1'b0, 1'b0);
        run_op("or",       4'd3,  32'hF0F0_1234,  32'h0FF0_FF00,  1'b0, 1'b0);
        run_op("xor",      4'd4,  32'hF0F0_1234,  32'h0FF0_FF00,  1'b0, 1'b0);
        run_op("sll",      4'd5,  32'd1,          32'hFFFF_FFDF,  1'b0, 1'b0);
        run_op("sra",      4'd7,  32'h8000_0000,  32'h24,         1'b0, 1'b0);
        run_op("srl",      4'd6,  32'h8000_0000,  32'h24,         1'b0, 1'b0);
        run_op("slt",      4'd8,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);
        run_op("sltu",     4'd9,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);
        run_op("rsv12",    4'd12, 32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 1'b0);
        run_op("add_cout", 4'd0,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);
        run_op("gaps",     4'd0,  32'h1234_5678,  32'h9ABC_DEF0,  1'b1, 1'b0);
        run_op("noise",    4'd0,  32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 1'b1);

        // Abort mid LOAD_B: opcode + all A beats + 3 B beats, then reset.
        send_op(4'd0, 32'h1111_1111, 32'h0000_2222, 1'b0, 1 + NB + 3);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cnt   = 0;
        repeat (3*NB) begin
            @(negedge clk);
            if (out_valid || busy) cnt++;
        end
        check_eq("abort no output", 64'(cnt), 64'd0);
        run_op("add_after_rst", 4'd0, 32'd2, 32'd2, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            bit [31:0] ra;
            bit [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op("rand", 4'($urandom_range(0, 15)), ra, rb,
                   1'($urandom), 1'($urandom));
        end

        // XLEN=16, DW=8 instance: 0xFFFF + 1.
        beats16[0] = 8'h00;
        beats16[1] = 8'hFF;
        beats16[2] = 8'hFF;
        beats16[3] = 8'h01;
        beats16[4] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_data2  = beats16[i];
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            in_valid2 = 1'b0;
        end while (!out_valid2 && k < 12);
        check_eq("x16 latency", 64'(k), 64'd2);
`ifdef DIFERENTIAL_RVB2_FLAGS_EN
        check_eq("x16 flags", 64'(flags2), 64'd3);
`endif
        got16 = 16'hFFFF;
        cnt   = 0;
        while (out_valid2 && cnt < 4) begin
            if (cnt < 2) got16[8*cnt +: 8] = out_data2;
            cnt++;
            @(negedge clk);
        end
        check_eq("x16 result", 64'(got16), 64'd0);
        check_eq("x16 beats", 64'(cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
